multi_burst_controller: RTL and testbench
=========================================

# multi_burst_controller

Read-burst engine that serves several cache requesters from one instruction/data memory port. It arbitrates round-robin between NUM_CH channels and supports linear or critical-word-first wrapping bursts. It issues one memory read per cycle to a memory of fixed, parametrised read latency, and returns tagged words to the requesting channel. It sits between the L1 caches and the shared memory port, and generalises the single-channel, two-cycles-per-word burst controller.

## Interface
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, word width; one word = 4 bytes of address space
- BLOCK_SIZE, 8, words per cache block; power of two, ≥2
- NUM_CH, 2, requester channels; ≥1
- MEM_LATENCY, 1, cycles from a mem_rd cycle to valid mem_data; 0..4 (0 = combinational memory)
- LW = $clog2(BLOCK_SIZE)+1; CW = max(1,$clog2(NUM_CH)) (derived, not overridable)

- clk  in  1  clock, all logic rising-edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  NUM_CH  per-channel request
- req_ready  out  NUM_CH  per-channel accept (one-hot or zero)
- req_addr  in  NUM_CH*ADDR_WIDTH  start byte address; channel i in slice i; bits [1:0] ignored
- req_len  in  NUM_CH*LW  words minus one
- req_wrap  in  NUM_CH  1 = wrapping full-block burst
- mem_rd  out  1  memory read strobe, registered
- mem_addr  out  ADDR_WIDTH  memory word address (bits [1:0]=0), registered
- mem_data  in  DATA_WIDTH  read data, valid MEM_LATENCY cycles after its mem_rd cycle
- rsp_valid  out  1  response word valid, registered
- rsp_ch  out  CW  channel owning rsp_data
- rsp_data  out  DATA_WIDTH  response word
- rsp_idx  out  LW-1  word offset of rsp_data within its block
- rsp_last  out  1  final word of burst, qualified by rsp_valid
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, ISSUE, DRAIN.
- IDLE:
  - Round-robin grant among asserted req_valid. Priority starts at the channel after the last granted one; after reset channel 0 has top priority.
  - req_ready is high only for the winner, combinationally, and only in IDLE.
  - Handshake = req_valid & req_ready. It latches addr, len, wrap and ch, then moves to ISSUE.
  - req_valid may drop without a handshake; no request is latched.
- Word count N:
  - Wrap mode: N = BLOCK_SIZE; req_len is ignored.
  - Linear mode: N = min(req_len, BLOCK_SIZE-1)+1.
- Address of word i (0..N-1):
  - Linear: start + 4i, modulo 2^ADDR_WIDTH.
  - Wrap: block base (start with the low log2(BLOCK_SIZE)+2 bits cleared) + 4·((start word offset + i) mod BLOCK_SIZE).
- ISSUE:
  - One mem_rd per cycle, N consecutive cycles, no bubbles.
  - After issuing word N-1, go to DRAIN. If MEM_LATENCY = 0, go directly to IDLE once the last response is registered.
- Response path:
  - A tag shift register, depth MEM_LATENCY, carries (valid, idx, last) alongside the memory pipeline.
  - When a tag emerges, mem_data is registered into rsp_data, with rsp_valid=1 and the tag's idx/last and the latched ch.
  - rsp_idx = word offset of that address within the block. The requester cannot stall responses.
- DRAIN: wait until the last tag has produced its response, then go to IDLE.
- New requests are not accepted outside IDLE; competing requests simply wait.

## Timing
- Handshake in cycle T; word i appears with mem_rd=1 in cycle T+1+i.
- rsp_valid for word i is high in cycle T+2+i+MEM_LATENCY.
- rsp_last is high in cycle T+1+N+MEM_LATENCY; state is IDLE in cycle T+2+N+MEM_LATENCY, when the next handshake is allowed.
- Throughput: 1 word/cycle inside a burst. Turnaround between bursts is MEM_LATENCY+2 cycles.
- Reset values: req_ready=0 while rst asserted, mem_rd=0, mem_addr=0, rsp_valid=0, rsp_ch=0, rsp_data=0, rsp_idx=0, rsp_last=0, busy=0, RR pointer favours channel 0.
- Reset mid-burst: the state machine, counters and tag pipeline clear immediately. No further rsp_valid or mem_rd until a new handshake; the partial burst is lost.
- rsp_valid, rsp_last and mem_rd are never X after reset; rsp_data is 0 whenever rsp_valid=0.

## Test plan
- Setup: NUM_CH=1, MEM_LATENCY=0, linear, addr 0x100, len 7 → mem_addr 0x100..0x11C on 8 consecutive cycles. 8 consecutive rsp_valid with idx 0..7; rsp_last only on the 8th; busy clears the next cycle.
- Setup: MEM_LATENCY=2, wrap, addr 0x214 (block 0x200, offset 5) → mem_addr 0x214,0x218,0x21C,0x200..0x210. rsp_idx 5,6,7,0,1,2,3,4. First rsp 4 cycles after the handshake.
- Setup: NUM_CH=2, both req_valid held high → grants alternate ch0, ch1, ch0. rsp_ch matches each burst, and no responses interleave.
- Linear burst with addr 0xFFFFFFF8, len 3 → addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4. req_len=15 with BLOCK_SIZE=8 → exactly 8 words.
- Reset asserted during word 3 of an 8-word burst with MEM_LATENCY=2 → all outputs return to reset values asynchronously, with no residual rsp_valid after release. The next request completes normally.
- req_valid pulsed for one cycle while busy, then dropped → never granted; no extra mem_rd.

Source files
------------

// File: rtl/multi_burst_controller.sv
// rtl/multi_burst_controller.sv - round-robin multi-channel read-burst engine
// Serves NUM_CH requesters with linear or critical-word-first bursts through one fixed-latency memory port.
module multi_burst_controller #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int BLOCK_SIZE  = 8,
  parameter int NUM_CH      = 2,
  parameter int MEM_LATENCY = 1,
  localparam int LW = $clog2(BLOCK_SIZE) + 1,
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            req_valid,
  output logic [NUM_CH-1:0]            req_ready,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_CH*LW-1:0]         req_len,
  input  logic [NUM_CH-1:0]            req_wrap,
  output logic                         mem_rd,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  input  logic [DATA_WIDTH-1:0]        mem_data,
  output logic                         rsp_valid,
  output logic [CW-1:0]                rsp_ch,
  output logic [DATA_WIDTH-1:0]        rsp_data,
  output logic [LW-2:0]                rsp_idx,
  output logic                         rsp_last,
  output logic                         busy
);
  localparam int OB = LW - 1;
  localparam int TW = OB + 2;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           prio_q, prio_d;
  logic [CW-1:0]           ch_q, ch_d;
  logic                    wrap_q, wrap_d;
  logic [OB-1:0]           last_q, last_d;
  logic [OB-1:0]           cnt_q, cnt_d;
  logic                    mem_rd_q, mem_rd_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [CW-1:0]           rsp_ch_q, rsp_ch_d;
  logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic [OB-1:0]           rsp_idx_q, rsp_idx_d;
  logic                    rsp_last_q, rsp_last_d;

  logic                    grant_ok;
  logic [CW-1:0]           grant_ch;
  int                      cand;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [LW-1:0]           sel_len;
  logic                    sel_wrap;
  logic [ADDR_WIDTH-1:0]   next_addr;
  logic [TW-1:0]           cur_tag, out_tag;
  logic                    unused_addr_lsb;

  // Scan channels starting at the priority pointer; first requester wins.
  always_comb begin
    grant_ok = 1'b0;
    grant_ch = '0;
    cand     = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = int'(prio_q) + k;
      if (cand >= NUM_CH) cand = cand - NUM_CH;
      if (!grant_ok && req_valid[CW'(cand)]) begin
        grant_ok = 1'b1;
        grant_ch = CW'(cand);
      end
    end
  end

  always_comb begin
    sel_addr  = '0;
    sel_len   = '0;
    sel_wrap  = 1'b0;
    req_ready = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (grant_ch == CW'(k)) begin
        sel_addr     = req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        sel_len      = req_len[k*LW +: LW];
        sel_wrap     = req_wrap[k];
        req_ready[k] = grant_ok && (state_q == IDLE) && !rst;
      end
    end
  end

  assign unused_addr_lsb = ^sel_addr[1:0];

  // Wrapping bursts increment only the block-offset field so the carry never leaves the block.
  assign next_addr = wrap_q ? {mem_addr_q[ADDR_WIDTH-1:OB+2], mem_addr_q[OB+1:2] + OB'(1), 2'b00}
                            : mem_addr_q + ADDR_WIDTH'(4);

  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    ch_d       = ch_q;
    wrap_d     = wrap_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    mem_rd_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    case (state_q)
      IDLE: begin
        if (grant_ok) begin
          state_d    = ISSUE;
          ch_d       = grant_ch;
          prio_d     = (int'(grant_ch) == NUM_CH - 1) ? '0 : grant_ch + CW'(1);
          wrap_d     = sel_wrap;
          last_d     = (sel_wrap || (sel_len > LW'(BLOCK_SIZE - 1))) ? OB'(BLOCK_SIZE - 1)
                                                                   : sel_len[OB-1:0];
          cnt_d      = '0;
          mem_rd_d   = 1'b1;
          mem_addr_d = {sel_addr[ADDR_WIDTH-1:2], 2'b00};
        end
      end
      ISSUE: begin
        if (cnt_q == last_q) begin
          state_d = DRAIN;
        end else begin
          mem_rd_d   = 1'b1;
          mem_addr_d = next_addr;
          cnt_d      = cnt_q + OB'(1);
        end
      end
      DRAIN: begin
        if (rsp_valid_q && rsp_last_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Tag = {valid, block offset, last} of the word currently on the memory port.
  assign cur_tag = {mem_rd_q, mem_addr_q[OB+1:2], (state_q == ISSUE) && (cnt_q == last_q)};

  generate
    if (MEM_LATENCY == 0) begin : g_comb_mem
      assign out_tag = cur_tag;
    end else begin : g_tag_pipe
      logic [MEM_LATENCY-1:0][TW-1:0] pipe_q, pipe_d;
      always_comb begin
        pipe_d    = pipe_q;
        pipe_d[0] = cur_tag;
        for (int k = 1; k < MEM_LATENCY; k++) pipe_d[k] = pipe_q[k-1];
      end
      always_ff @(posedge clk or posedge rst) begin
        if (rst) pipe_q <= '0;
        else     pipe_q <= pipe_d;
      end
      assign out_tag = pipe_q[MEM_LATENCY-1];
    end
  endgenerate

  always_comb begin
    rsp_valid_d = out_tag[TW-1];
    rsp_data_d  = out_tag[TW-1] ? mem_data : '0;
    rsp_idx_d   = out_tag[TW-1] ? out_tag[TW-2:1] : '0;
    rsp_last_d  = out_tag[TW-1] & out_tag[0];
    rsp_ch_d    = out_tag[TW-1] ? ch_q : rsp_ch_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      prio_q      <= '0;
      ch_q        <= '0;
      wrap_q      <= 1'b0;
      last_q      <= '0;
      cnt_q       <= '0;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_ch_q    <= '0;
      rsp_data_q  <= '0;
      rsp_idx_q   <= '0;
      rsp_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      ch_q        <= ch_d;
      wrap_q      <= wrap_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      mem_rd_q    <= mem_rd_d;
      mem_addr_q  <= mem_addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_ch_q    <= rsp_ch_d;
      rsp_data_q  <= rsp_data_d;
      rsp_idx_q   <= rsp_idx_d;
      rsp_last_q  <= rsp_last_d;
    end
  end

  assign mem_rd    = mem_rd_q;
  assign mem_addr  = mem_addr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_ch    = rsp_ch_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_idx   = rsp_idx_q;
  assign rsp_last  = rsp_last_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_multi_burst_controller.sv
// tb/tb_multi_burst_controller.sv - randomized self-checking bench for multi_burst_controller
// Expected traffic comes from a burst-level address/timing model and a hashed memory image.
module tb_multi_burst_controller;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int BS  = 8;
  localparam int NCH = 2;
  localparam int LAT = 2;
  localparam int LW  = $clog2(BS) + 1;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NCH-1:0]      req_valid = '0;
  logic [NCH-1:0]      req_ready;
  logic [NCH*AW-1:0]   req_addr;
  logic [NCH*LW-1:0]   req_len;
  logic [NCH-1:0]      req_wrap = '0;
  logic                mem_rd;
  logic [AW-1:0]       mem_addr;
  logic [DW-1:0]       mem_data;
  logic                rsp_valid;
  logic [0:0]          rsp_ch;
  logic [DW-1:0]       rsp_data;
  logic [LW-2:0]       rsp_idx;
  logic                rsp_last;
  logic                busy;

  logic [AW-1:0]       cfg_addr [NCH];
  logic [LW-1:0]       cfg_len  [NCH];
  logic [AW-1:0]       hist     [LAT];

  int checks = 0;
  int errors = 0;
  int prio_m = 0;
  int hs_wait = 0;
  int win;

  for (genvar g = 0; g < NCH; g++) begin : g_req
    assign req_addr[g*AW +: AW] = cfg_addr[g];
    assign req_len[g*LW +: LW]  = cfg_len[g];
  end

  multi_burst_controller #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BLOCK_SIZE(BS), .NUM_CH(NCH), .MEM_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_len(req_len), .req_wrap(req_wrap),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
    .rsp_valid(rsp_valid), .rsp_ch(rsp_ch), .rsp_data(rsp_data),
    .rsp_idx(rsp_idx), .rsp_last(rsp_last), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Memory with LAT cycles of read latency.
  always @(posedge clk) begin
    for (int k = LAT - 1; k > 0; k--) hist[k] <= hist[k-1];
    hist[0] <= mem_addr;
  end
  assign mem_data = mem_word(hist[LAT-1]);

  function automatic int burst_words(input logic [LW-1:0] len, input logic wrap);
    if (wrap) return BS;
    return ((int'(len) > BS - 1) ? BS - 1 : int'(len)) + 1;
  endfunction

  function automatic logic [31:0] word_addr(input logic [31:0] a, input logic wrap, input int i);
    logic [31:0] base;
    int off;
    if (!wrap) return (a & ~32'h3) + 32'(4 * i);
    base = a & ~32'(BS * 4 - 1);
    off  = int'((a >> 2) % BS);
    return base + 32'(4 * ((off + i) % BS));
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_mem_rd", 32'(mem_rd), 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_ch", 32'(rsp_ch), 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_idx", 32'(rsp_idx), 0);
    check("rst_rsp_last", 32'(rsp_last), 0);
    check("rst_busy", 32'(busy), 0);
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check("idle_mem_rd", 32'(mem_rd), 0);
      check("idle_rsp_valid", 32'(rsp_valid), 0);
      check("idle_busy", 32'(busy), 0);
    end
  endtask

  // Waits for a handshake, then checks every cycle of the burst against the model.
  task automatic run_burst(input bit hold, input int pulse_at, input int rst_at, output int w_out);
    bit found;
    int exp_win, n, i, other;
    logic [NCH-1:0] exp_rdy;
    logic [31:0] a, ea;
    logic [LW-1:0] l;
    logic w;
    found = 1'b0;
    w_out = -1;
    hs_wait = 0;
    for (int t = 0; t < 40; t++) begin
      #1;
      if ((req_valid & req_ready) != '0) begin
        found = 1'b1;
        hs_wait = t;
        break;
      end
      @(negedge clk);
    end
    if (!found) begin
      check("hs_timeout", 0, 1);
      return;
    end
    exp_win = -1;
    for (int k = 0; k < NCH; k++)
      if (exp_win < 0 && req_valid[(prio_m + k) % NCH]) exp_win = (prio_m + k) % NCH;
    exp_rdy = NCH'(1) << exp_win;
    check("grant", 32'(req_ready), 32'(exp_rdy));
    w_out  = exp_win;
    prio_m = (exp_win + 1) % NCH;
    other  = (exp_win + 1) % NCH;
    a = cfg_addr[exp_win];
    l = cfg_len[exp_win];
    w = req_wrap[exp_win];
    n = burst_words(l, w);
    for (int c = 1; c <= n + LAT + 2; c++) begin
      @(negedge clk);
      check("busy", 32'(busy), 32'(c <= n + LAT + 1));
      check("mem_rd", 32'(mem_rd), 32'(c <= n));
      if (c <= n) check("mem_addr", mem_addr, word_addr(a, w, c - 1));
      check("rsp_valid", 32'(rsp_valid), 32'((c >= 2 + LAT) && (c <= 1 + n + LAT)));
      if ((c >= 2 + LAT) && (c <= 1 + n + LAT)) begin
        i  = c - 2 - LAT;
        ea = word_addr(a, w, i);
        check("rsp_data", rsp_data, mem_word(ea));
        check("rsp_idx", 32'(rsp_idx), (ea >> 2) % BS);
        check("rsp_last", 32'(rsp_last), 32'(i == n - 1));
        check("rsp_ch", 32'(rsp_ch), 32'(exp_win));
      end else begin
        check("rsp_data_zero", rsp_data, 0);
        check("rsp_last_idle", 32'(rsp_last), 0);
      end
      if (c <= n + LAT + 1) check("ready_busy", 32'(req_ready), 0);
      if (c == 1 && !hold) req_valid[exp_win] = 1'b0;
      if (pulse_at > 0 && c == pulse_at) req_valid[other] = 1'b1;
      if (pulse_at > 0 && c == pulse_at + 1) req_valid[other] = 1'b0;
      if (rst_at > 0 && c == rst_at) begin
        rst = 1'b1;
        req_valid = '0;
        #1;
        check_reset_outputs();
        prio_m = 0;
        return;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < NCH; k++) begin
      cfg_addr[k] = '0;
      cfg_len[k]  = '0;
    end
    req_valid = '1;
    repeat (2) @(negedge clk);
    check_reset_outputs();
    req_valid = '0;
    rst = 1'b0;
    prio_m = 0;
    @(negedge clk);

    cfg_addr[0] = 32'h100; cfg_len[0] = 4'd7; req_wrap[0] = 1'b0; req_valid[0] = 1'b1;
    run_burst(1'b0, 0, 0, win);
    check("lin_win", win, 0);

    cfg_addr[1] = 32'h214; cfg_len[1] = 4'd0; req_wrap[1] = 1'b1; req_valid[1] = 1'b1;
    run_burst(1'b0, 0, 0, win);
    check("wrap_win", win, 1);

    cfg_addr[0] = 32'hFFFF_FFF8; cfg_len[0] = 4'd3; req_wrap[0] = 1'b0; req_valid[0] = 1'b1;
    run_burst(1'b0, 0, 0, win);

    cfg_addr[1] = 32'h40; cfg_len[1] = 4'd15; req_wrap[1] = 1'b0; req_valid[1] = 1'b1;
    run_burst(1'b0, 0, 0, win);

    cfg_addr[0] = 32'h600; cfg_len[0] = 4'd5; req_valid[0] = 1'b1;
    run_burst(1'b0, 3, 0, win);
    idle_cycles(4);

    cfg_addr[0] = 32'h300; cfg_len[0] = 4'd7; req_valid[0] = 1'b1;
    run_burst(1'b0, 0, 4, win);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle_cycles(5);
    cfg_addr[1] = 32'h500; cfg_len[1] = 4'd5; req_wrap[1] = 1'b0; req_valid[1] = 1'b1;
    run_burst(1'b0, 0, 0, win);
    check("post_rst_win", win, 1);

    cfg_addr[0] = 32'h800; cfg_len[0] = 4'd2; req_wrap[0] = 1'b0;
    cfg_addr[1] = 32'h90C; cfg_len[1] = 4'd1; req_wrap[1] = 1'b1;
    req_valid = '1;
    run_burst(1'b1, 0, 0, win);
    check("held_win0", win, 0);
    run_burst(1'b1, 0, 0, win);
    check("held_win1", win, 1);
    check("turnaround1", hs_wait, 0);
    run_burst(1'b1, 0, 0, win);
    check("held_win2", win, 0);
    check("turnaround2", hs_wait, 0);
    req_valid = '0;
    idle_cycles(2);

    for (int r = 0; r < 40; r++) begin
      for (int k = 0; k < NCH; k++) begin
        cfg_addr[k] = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | 32'($urandom_range(0, 31)))
                                                  : $urandom();
        cfg_len[k]  = LW'($urandom_range(0, 15));
        req_wrap[k] = 1'($urandom_range(0, 1));
      end
      req_valid = NCH'($urandom_range(1, 3));
      run_burst(1'b0, 0, 0, win);
    end
    req_valid = '0;
    idle_cycles(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
